// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared state encoding and sizing helper for seq_divider
package seq_div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: shift in a dividend bit, trial subtract
module div_step #(
  parameter int W = 4
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] dvs,
  input  logic         bit_in,
  output logic [W-1:0] rem_out,
  output logic         qbit
);

  localparam logic SUB = 1'b1;

  logic [W:0] shifted;
  logic [W:0] bx;
  logic [W:0] diff;

  // rem < dvs on entry, so shifted - dvs always fits in W+1 signed bits
  assign shifted = {rem, bit_in};
  assign bx      = {1'b0, dvs} ^ {(W+1){SUB}};
  assign diff    = shifted + bx + {{W{1'b0}}, SUB};
  assign qbit    = ~diff[W];
  assign rem_out = qbit ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider, signed/unsigned, W+1 cycle latency
// Optional remainder output and sign fix: SEQ_DIV_REMAINDER_EN
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         u,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic         v
`ifdef SEQ_DIV_REMAINDER_EN
  ,
  output logic [W-1:0] r
`endif
);

  localparam int            CW    = cnt_width(W);
  localparam logic [W-1:0]  ONE   = W'(1);
  localparam logic [W-1:0]  MIN_S = {1'b1, {(W-1){1'b0}}};

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   dvd;
  logic [W-1:0]   dvs;
  logic [W-1:0]   rem;
  logic           neg_q;
  logic           div0;
  logic           ovf;
  logic [W-1:0]   rem_nx;
  logic           qbit;
  logic [W-1:0]   a_abs;
  logic [W-1:0]   b_abs;
`ifdef SEQ_DIV_REMAINDER_EN
  logic           neg_r;
  logic [W-1:0]   a_keep;
`endif

  always_comb begin
    a_abs = (~u & a[W-1]) ? (~a + ONE) : a;
    b_abs = (~u & b[W-1]) ? (~b + ONE) : b;
  end

  div_step #(.W(W)) u_step (
    .rem     (rem),
    .dvs     (dvs),
    .bit_in  (dvd[W-1]),
    .rem_out (rem_nx),
    .qbit    (qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      neg_q <= 1'b0;
      div0  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      q     <= '0;
      v     <= 1'b0;
`ifdef SEQ_DIV_REMAINDER_EN
      neg_r  <= 1'b0;
      a_keep <= '0;
      r      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd   <= a_abs;
            dvs   <= b_abs;
            rem   <= '0;
            neg_q <= ~u & (a[W-1] ^ b[W-1]);
            div0  <= (b == '0);
            ovf   <= ~u & (a == MIN_S) & (b == '1);
            cnt   <= CW'(W-1);
            busy  <= 1'b1;
            state <= CALC;
`ifdef SEQ_DIV_REMAINDER_EN
            neg_r  <= ~u & a[W-1];
            a_keep <= a;
`endif
          end
        end
        CALC: begin
          // dvd doubles as the quotient shift register as dividend bits drain out
          rem <= rem_nx;
          dvd <= {dvd[W-2:0], qbit};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - CW'(1);
        end
        FIX: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          v     <= div0 | ovf;
          if (div0)       q <= '1;
          else if (neg_q) q <= ~dvd + ONE;
          else            q <= dvd;
`ifdef SEQ_DIV_REMAINDER_EN
          if (div0)       r <= a_keep;
          else if (neg_r) r <= ~rem + ONE;
          else            r <= rem;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider (W=4)
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] a, b;
  logic       u;
  logic       busy, done, v;
  logic [3:0] q;
  logic [3:0] r_obs;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

`ifdef SEQ_DIV_REMAINDER_EN
  logic [3:0] r;
  assign r_obs = r;
  seq_divider #(.W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .u(u),
    .busy(busy), .done(done), .q(q), .v(v), .r(r)
  );
`else
  assign r_obs = 4'h0;
  seq_divider #(.W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .u(u),
    .busy(busy), .done(done), .q(q), .v(v)
  );
`endif

  task automatic do_div(input logic [3:0] ta, input logic [3:0] tb, input logic tu,
                        output int lat, output logic bsy, output logic [3:0] oq,
                        output logic ov, output logic [3:0] orr);
    @(negedge clk);
    a = ta; b = tb; u = tu; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bsy = busy;
    a = 4'($urandom); b = 4'($urandom); u = 1'($urandom);
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    oq = q; ov = v; orr = r_obs;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 4'h0; b = 4'h0; u = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, v, q, r_obs} !== 7'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b v=%b q=%h r=%h, want all 0", busy, done, v, q, r_obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    int lat; logic bsy; logic [3:0] oq, orr; logic ov;
    logic [3:0] va[3] = '{4'd13, 4'd15, 4'd7};
    logic [3:0] vb[3] = '{4'd4,  4'd1,  4'd9};
    logic [3:0] eq[3] = '{4'd3,  4'd15, 4'd0};
    logic [3:0] er[3] = '{4'd1,  4'd0,  4'd7};
    for (int i = 0; i < 3; i++) begin
      do_div(va[i], vb[i], 1'b1, lat, bsy, oq, ov, orr);
      vectors++;
      if (lat !== 5 || bsy !== 1'b1 || oq !== eq[i] || ov !== 1'b0) begin
        miscompares++;
        $display("FAIL unsigned %0d/%0d: got lat=%0d busy=%b q=%h v=%b, want lat=5 busy=1 q=%h v=0",
                 va[i], vb[i], lat, bsy, oq, ov, eq[i]);
      end
`ifdef SEQ_DIV_REMAINDER_EN
      vectors++;
      if (orr !== er[i]) begin
        miscompares++;
        $display("FAIL unsigned_rem %0d/%0d: got r=%h, want %h", va[i], vb[i], orr, er[i]);
      end
`endif
    end
  endtask

  task automatic test_signed();
    int lat; logic bsy; logic [3:0] oq, orr; logic ov;
    logic [3:0] va[3] = '{4'h9, 4'h7, 4'h8};
    logic [3:0] vb[3] = '{4'h2, 4'hE, 4'h3};
    logic [3:0] eq[3] = '{4'hD, 4'hD, 4'hE};
    logic [3:0] er[3] = '{4'hF, 4'h1, 4'hE};
    for (int i = 0; i < 3; i++) begin
      do_div(va[i], vb[i], 1'b0, lat, bsy, oq, ov, orr);
      vectors++;
      if (lat !== 5 || oq !== eq[i] || ov !== 1'b0) begin
        miscompares++;
        $display("FAIL signed %h/%h: got lat=%0d q=%h v=%b, want lat=5 q=%h v=0", va[i], vb[i], lat, oq, ov, eq[i]);
      end
`ifdef SEQ_DIV_REMAINDER_EN
      vectors++;
      if (orr !== er[i]) begin
        miscompares++;
        $display("FAIL signed_rem %h/%h: got r=%h, want %h", va[i], vb[i], orr, er[i]);
      end
`endif
    end
  endtask

  task automatic test_errors();
    int lat; logic bsy; logic [3:0] oq, orr; logic ov;
    logic [3:0] va[3] = '{4'h5, 4'hA, 4'h8};
    logic [3:0] vb[3] = '{4'h0, 4'h0, 4'hF};
    logic       vu[3] = '{1'b1, 1'b0, 1'b0};
    logic [3:0] eq[3] = '{4'hF, 4'hF, 4'h8};
    logic [3:0] er[3] = '{4'h5, 4'hA, 4'h0};
    for (int i = 0; i < 3; i++) begin
      do_div(va[i], vb[i], vu[i], lat, bsy, oq, ov, orr);
      vectors++;
      if (lat !== 5 || oq !== eq[i] || ov !== 1'b1) begin
        miscompares++;
        $display("FAIL error_case %h/%h u=%b: got lat=%0d q=%h v=%b, want lat=5 q=%h v=1",
                 va[i], vb[i], vu[i], lat, oq, ov, eq[i]);
      end
`ifdef SEQ_DIV_REMAINDER_EN
      vectors++;
      if (orr !== er[i]) begin
        miscompares++;
        $display("FAIL error_rem %h/%h: got r=%h, want %h", va[i], vb[i], orr, er[i]);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    int n_done = 0; int first = 0; logic [3:0] qq = 4'h0; logic [3:0] rr = 4'h0;
    @(negedge clk);
    a = 4'd15; b = 4'd1; u = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      if (done) begin n_done++; first = i; qq = q; end
      if (i == 1) begin a = 4'd3; b = 4'd3; start = 1'b1; end
      if (i == 2) start = 1'b0;
    end
    vectors++;
    if (n_done !== 1 || first !== 5 || qq !== 4'd15) begin
      miscompares++;
      $display("FAIL busy_ignore: got dones=%0d at=%0d q=%h, want dones=1 at=5 q=f", n_done, first, qq);
    end
    a = 4'd9; b = 4'd2; u = 1'b1; start = 1'b1;
    n_done = 0; first = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) start = 1'b0;
      if (done) begin n_done++; first = i; qq = q; rr = r_obs; end
    end
    vectors++;
    if (n_done !== 1 || first !== 6 || qq !== 4'd4) begin
      miscompares++;
      $display("FAIL back_to_back: got dones=%0d at=%0d q=%h, want dones=1 at=6 q=4", n_done, first, qq);
    end
`ifdef SEQ_DIV_REMAINDER_EN
    vectors++;
    if (rr !== 4'd1) begin
      miscompares++;
      $display("FAIL back_to_back_rem: got r=%h, want 1", rr);
    end
`endif
  endtask

  task automatic test_reset_abort();
    int lat; logic bsy; logic [3:0] oq, orr; logic ov;
    int n_done = 0;
    @(negedge clk);
    a = 4'd12; b = 4'd5; u = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, v, q, r_obs} !== 7'h0) begin
      miscompares++;
      $display("FAIL reset_abort_outputs: got busy=%b done=%b v=%b q=%h r=%h, want all 0", busy, done, v, q, r_obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    vectors++;
    if (n_done !== 0) begin
      miscompares++;
      $display("FAIL reset_abort_no_done: got %0d done pulses, want 0", n_done);
    end
    do_div(4'd12, 4'd5, 1'b1, lat, bsy, oq, ov, orr);
    vectors++;
    if (lat !== 5 || oq !== 4'd2 || ov !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset 12/5: got lat=%0d q=%h v=%b, want lat=5 q=2 v=0", lat, oq, ov);
    end
`ifdef SEQ_DIV_REMAINDER_EN
    vectors++;
    if (orr !== 4'd2) begin
      miscompares++;
      $display("FAIL after_reset_rem 12/5: got r=%h, want 2", orr);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
